udma_spim_mch_reg_if: RTL and testbench

Parametrised multi-channel register interface for the uDMA SPI master. It replaces the fixed CMD/RX/TX register file with N_CH identical channel register sets, addressed from the APB-side cfg bus and from the in-stream UCA/UCS setup commands by channel index. It adds three things per channel: a one-entry deferred-enable slot for UCS commands that arrive while the channel is already pending, a transfer-complete counter, and cfg-write back-pressure on collisions. It sits between the peripheral cfg bus and the uDMA channel controllers.

---
 rtl/udma_spim_mch_pkg.sv | 33 +++
 rtl/udma_spim_ch_regs.sv | 107 ++++++++++
 rtl/udma_spim_mch_reg_if.sv | 166 ++++++++++++++++
 tb/tb_udma_spim_mch_reg_if.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_spim_mch_pkg.sv
// Shared constants for the multi-channel uDMA SPI master register interface:
// register offsets, setup-command opcodes/fields and CFG/STATUS bit positions.
package udma_spim_mch_pkg;

    localparam logic [1:0] REG_SADDR  = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_CFG    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [3:0] SPI_CMD_SETUP_UCA = 4'b1101;
    localparam logic [3:0] SPI_CMD_SETUP_UCS = 4'b1110;

    localparam int CMD_OP_MSB = 31;
    localparam int CMD_OP_LSB = 28;
    localparam int CMD_CH_MSB = 27;
    localparam int CMD_CH_LSB = 25;
    localparam int CMD_DS_MSB = 24;
    localparam int CMD_DS_LSB = 23;

    localparam int CFG_CONT_BIT = 0;
    localparam int CFG_DS_LSB   = 1;
    localparam int CFG_EN_BIT   = 4;
    localparam int CFG_CLR_BIT  = 5;
    localparam int CFG_PEND_BIT = 5;

    localparam int STAT_DVALID_BIT = 0;
    localparam int STAT_OVF_BIT    = 1;
    localparam int STAT_CNTCLR_BIT = 2;
    localparam int STAT_CNT_LSB    = 8;

    localparam logic [1:0] DS_RESET = 2'b10;

endpackage

// File: rtl/udma_spim_ch_regs.sv
// One channel's register set: start address, size, datasize, continuous,
// one-entry deferred UCS slot, sticky overflow and transfer-complete counter.
module udma_spim_ch_regs
    import udma_spim_mch_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int CNT_W          = 8,
    parameter bit CMD_CH         = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_saddr,
    input  logic                      wr_size,
    input  logic                      wr_cfg,
    input  logic                      wr_status,
    input  logic [31:0]               wdata,
    input  logic                      uca_hit,
    input  logic                      ucs_hit,
    input  logic [L2_AWIDTH_NOAL-1:0] cmd_addr,
    input  logic [TRANS_SIZE-1:0]     cmd_size,
    input  logic [1:0]                cmd_ds,
    input  logic                      apply,
    input  logic                      en_i,
    input  logic                      pending_i,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr,
    output logic [TRANS_SIZE-1:0]     size,
    output logic [1:0]                datasize,
    output logic                      continuous,
    output logic                      en_pulse,
    output logic                      clr_pulse,
    output logic                      dvalid,
    output logic                      ovf,
    output logic [CNT_W-1:0]          cnt
);

    logic [TRANS_SIZE-1:0] slot_size;
    logic [1:0]            slot_ds;
    logic                  en_q;
    logic                  unused_in;

    assign unused_in = ^{wdata, cmd_ds};

    // The command channel keeps its datasize fixed; only the stall logic in
    // the top guarantees cfg writes never coincide with a hit or an apply.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            startaddr  <= '0;
            size       <= '0;
            datasize   <= DS_RESET;
            continuous <= 1'b0;
            en_pulse   <= 1'b0;
            clr_pulse  <= 1'b0;
            dvalid     <= 1'b0;
            ovf        <= 1'b0;
            cnt        <= '0;
            slot_size  <= '0;
            slot_ds    <= '0;
            en_q       <= 1'b0;
        end else begin
            en_pulse  <= 1'b0;
            clr_pulse <= 1'b0;
            en_q      <= en_i;

            if (uca_hit)
                startaddr <= cmd_addr;
            else if (wr_saddr)
                startaddr <= wdata[L2_AWIDTH_NOAL-1:0];

            if (wr_status && wdata[STAT_OVF_BIT])
                ovf <= 1'b0;

            if (ucs_hit) begin
                if (!pending_i && !dvalid) begin
                    size     <= cmd_size;
                    if (!CMD_CH) datasize <= cmd_ds;
                    en_pulse <= 1'b1;
                end else if (!dvalid) begin
                    slot_size <= cmd_size;
                    slot_ds   <= cmd_ds;
                    dvalid    <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (apply) begin
                size     <= slot_size;
                if (!CMD_CH) datasize <= slot_ds;
                en_pulse <= 1'b1;
                dvalid   <= 1'b0;
            end else if (wr_size) begin
                size <= wdata[TRANS_SIZE-1:0];
            end else if (wr_cfg) begin
                clr_pulse  <= wdata[CFG_CLR_BIT];
                en_pulse   <= wdata[CFG_EN_BIT];
                continuous <= wdata[CFG_CONT_BIT];
                if (!CMD_CH) datasize <= wdata[CFG_DS_LSB +: 2];
                if (wdata[CFG_CLR_BIT]) dvalid <= 1'b0;
            end

            if (wr_status && wdata[STAT_CNTCLR_BIT])
                cnt <= '0;
            else if (en_q && !en_i && cnt != {CNT_W{1'b1}})
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/udma_spim_mch_reg_if.sv
// Multi-channel uDMA SPI master register interface: cfg/command decode,
// deferred-apply arbitration, read mux and cfg back-pressure.
module udma_spim_mch_reg_if
    import udma_spim_mch_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int N_CH           = 3,
    parameter int REG_AWIDTH     = 5,
    parameter int CNT_W          = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [31:0]                          cfg_data_i,
    input  logic [REG_AWIDTH-1:0]                cfg_addr_i,
    input  logic                                 cfg_valid_i,
    input  logic                                 cfg_rwn_i,
    output logic [31:0]                          cfg_data_o,
    output logic                                 cfg_ready_o,
    output logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_startaddr_o,
    output logic [N_CH-1:0][TRANS_SIZE-1:0]      cfg_size_o,
    output logic [N_CH-1:0][1:0]                 cfg_datasize_o,
    output logic [N_CH-1:0]                      cfg_continuous_o,
    output logic [N_CH-1:0]                      cfg_en_o,
    output logic [N_CH-1:0]                      cfg_clr_o,
    input  logic [N_CH-1:0]                      cfg_en_i,
    input  logic [N_CH-1:0]                      cfg_pending_i,
    input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_curr_addr_i,
    input  logic [N_CH-1:0][TRANS_SIZE-1:0]      cfg_bytes_left_i,
    input  logic [31:0]                          udma_cmd_i,
    input  logic                                 udma_cmd_valid_i,
    input  logic                                 udma_cmd_ready_i
);

    localparam int CHW = REG_AWIDTH - 2;

    logic [CHW-1:0] reg_ch;
    logic [1:0]     reg_sel;
    logic           addr_ok, wr_req, wr_go;
    logic [3:0]     cmd_op;
    logic [2:0]     cmd_ch;
    logic           cmd_fire, cmd_ch_ok, uca_any, ucs_any, cmd_hit, apply_any;
    logic           unused_cmd;

    logic [N_CH-1:0] uca_hit, ucs_hit, clr_req, apply_req, apply_gnt;
    logic [N_CH-1:0] wr_saddr, wr_size, wr_cfg, wr_status;
    logic [N_CH-1:0] dvalid, ovf;
    logic [N_CH-1:0][CNT_W-1:0] cnt;

    assign reg_ch  = cfg_addr_i[REG_AWIDTH-1:2];
    assign reg_sel = cfg_addr_i[1:0];
    assign addr_ok = 32'(reg_ch) < N_CH;
    assign wr_req  = cfg_valid_i && !cfg_rwn_i;

    assign cmd_op    = udma_cmd_i[CMD_OP_MSB:CMD_OP_LSB];
    assign cmd_ch    = udma_cmd_i[CMD_CH_MSB:CMD_CH_LSB];
    assign cmd_fire  = udma_cmd_valid_i && udma_cmd_ready_i;
    assign cmd_ch_ok = (cmd_ch != 3'd0) && (32'(cmd_ch) < N_CH);
    assign uca_any   = cmd_fire && cmd_ch_ok && (cmd_op == SPI_CMD_SETUP_UCA);
    assign ucs_any   = cmd_fire && cmd_ch_ok && (cmd_op == SPI_CMD_SETUP_UCS);
    assign cmd_hit   = uca_any || ucs_any;
    assign unused_cmd = ^udma_cmd_i;

    always_comb begin
        uca_hit = '0;
        ucs_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cmd_ch == 3'(c)) begin
                uca_hit[c] = uca_any;
                ucs_hit[c] = ucs_any;
            end
        end
    end

    // A pending clr on a channel suppresses its apply so clr wins cleanly.
    always_comb begin
        clr_req = '0;
        for (int c = 0; c < N_CH; c++)
            clr_req[c] = wr_req && addr_ok && (reg_ch == CHW'(c)) &&
                         (reg_sel == REG_CFG) && cfg_data_i[CFG_CLR_BIT];
    end

    always_comb begin
        apply_req = dvalid & ~cfg_pending_i & ~ucs_hit & ~clr_req;
        apply_gnt = '0;
        for (int c = N_CH - 1; c >= 1; c--)
            if (apply_req[c]) apply_gnt = N_CH'(1) << c;
    end

    assign apply_any   = |apply_gnt;
    assign cfg_ready_o = !(wr_req && (cmd_hit || apply_any));
    assign wr_go       = wr_req && cfg_ready_o && addr_ok;

    always_comb begin
        wr_saddr  = '0;
        wr_size   = '0;
        wr_cfg    = '0;
        wr_status = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (wr_go && reg_ch == CHW'(c)) begin
                wr_saddr[c]  = reg_sel == REG_SADDR;
                wr_size[c]   = reg_sel == REG_SIZE;
                wr_cfg[c]    = reg_sel == REG_CFG;
                wr_status[c] = reg_sel == REG_STATUS;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        udma_spim_ch_regs #(
            .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
            .TRANS_SIZE     (TRANS_SIZE),
            .CNT_W          (CNT_W),
            .CMD_CH         (g == 0)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .wr_saddr   (wr_saddr[g]),
            .wr_size    (wr_size[g]),
            .wr_cfg     (wr_cfg[g]),
            .wr_status  (wr_status[g]),
            .wdata      (cfg_data_i),
            .uca_hit    (uca_hit[g]),
            .ucs_hit    (ucs_hit[g]),
            .cmd_addr   (udma_cmd_i[L2_AWIDTH_NOAL-1:0]),
            .cmd_size   (udma_cmd_i[TRANS_SIZE-1:0]),
            .cmd_ds     (udma_cmd_i[CMD_DS_MSB:CMD_DS_LSB]),
            .apply      (apply_gnt[g]),
            .en_i       (cfg_en_i[g]),
            .pending_i  (cfg_pending_i[g]),
            .startaddr  (cfg_startaddr_o[g]),
            .size       (cfg_size_o[g]),
            .datasize   (cfg_datasize_o[g]),
            .continuous (cfg_continuous_o[g]),
            .en_pulse   (cfg_en_o[g]),
            .clr_pulse  (cfg_clr_o[g]),
            .dvalid     (dvalid[g]),
            .ovf        (ovf[g]),
            .cnt        (cnt[g])
        );
    end

    always_comb begin
        cfg_data_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (addr_ok && reg_ch == CHW'(c)) begin
                case (reg_sel)
                    REG_SADDR: cfg_data_o[L2_AWIDTH_NOAL-1:0] = cfg_curr_addr_i[c];
                    REG_SIZE:  cfg_data_o[TRANS_SIZE-1:0]     = cfg_bytes_left_i[c];
                    REG_CFG: begin
                        cfg_data_o[CFG_PEND_BIT]     = cfg_pending_i[c];
                        cfg_data_o[CFG_EN_BIT]       = cfg_en_i[c];
                        cfg_data_o[CFG_DS_LSB +: 2]  = cfg_datasize_o[c];
                        cfg_data_o[CFG_CONT_BIT]     = cfg_continuous_o[c];
                    end
                    default: begin
                        cfg_data_o[STAT_CNT_LSB +: CNT_W] = cnt[c];
                        cfg_data_o[STAT_OVF_BIT]          = ovf[c];
                        cfg_data_o[STAT_DVALID_BIT]       = dvalid[c];
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udma_spim_mch_reg_if.sv
// Scoreboard bench for udma_spim_mch_reg_if; a second instance with CNT_W=2
// shares all inputs so counter saturation can be observed alongside.
module tb_udma_spim_mch_reg_if;

    localparam int S_RD      = 0;
    localparam int S_RD2     = 1;
    localparam int S_RDY     = 2;
    localparam int S_SIZE    = 3;
    localparam int S_DS      = 4;
    localparam int S_SADDR   = 5;
    localparam int S_EN      = 6;
    localparam int S_CLR     = 7;
    localparam int S_DSALL   = 8;
    localparam int S_SIZEALL = 9;
    localparam int S_CONT    = 10;

    typedef struct {
        string       name;
        int          sel;
        int          ch;
        logic [63:0] exp;
    } sb_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [31:0]        cfg_data_i = '0;
    logic [4:0]         cfg_addr_i = '0;
    logic               cfg_valid_i = 1'b0;
    logic               cfg_rwn_i = 1'b1;
    logic [2:0]         cfg_en_i = '0;
    logic [2:0]         cfg_pending_i = '0;
    logic [2:0][11:0]   cfg_curr_addr_i = '0;
    logic [2:0][15:0]   cfg_bytes_left_i = '0;
    logic [31:0]        udma_cmd_i = '0;
    logic               udma_cmd_valid_i = 1'b0;
    logic               udma_cmd_ready_i = 1'b1;

    logic [31:0]        cfg_data_o, cfg_data_o2;
    logic               cfg_ready_o, cfg_ready_o2;
    logic [2:0][11:0]   cfg_startaddr_o, cfg_startaddr_o2;
    logic [2:0][15:0]   cfg_size_o, cfg_size_o2;
    logic [2:0][1:0]    cfg_datasize_o, cfg_datasize_o2;
    logic [2:0]         cfg_continuous_o, cfg_continuous_o2;
    logic [2:0]         cfg_en_o, cfg_en_o2;
    logic [2:0]         cfg_clr_o, cfg_clr_o2;

    sb_t         sbq[$];
    sb_t         cur;
    logic [63:0] act;
    int          n_compared = 0;
    int          n_mismatched = 0;

    always #5 clk_i = ~clk_i;

    udma_spim_mch_reg_if #(.N_CH(3), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_startaddr_o(cfg_startaddr_o), .cfg_size_o(cfg_size_o),
        .cfg_datasize_o(cfg_datasize_o), .cfg_continuous_o(cfg_continuous_o),
        .cfg_en_o(cfg_en_o), .cfg_clr_o(cfg_clr_o),
        .cfg_en_i(cfg_en_i), .cfg_pending_i(cfg_pending_i),
        .cfg_curr_addr_i(cfg_curr_addr_i), .cfg_bytes_left_i(cfg_bytes_left_i),
        .udma_cmd_i(udma_cmd_i), .udma_cmd_valid_i(udma_cmd_valid_i),
        .udma_cmd_ready_i(udma_cmd_ready_i)
    );

    udma_spim_mch_reg_if #(.N_CH(3), .CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_data_o(cfg_data_o2), .cfg_ready_o(cfg_ready_o2),
        .cfg_startaddr_o(cfg_startaddr_o2), .cfg_size_o(cfg_size_o2),
        .cfg_datasize_o(cfg_datasize_o2), .cfg_continuous_o(cfg_continuous_o2),
        .cfg_en_o(cfg_en_o2), .cfg_clr_o(cfg_clr_o2),
        .cfg_en_i(cfg_en_i), .cfg_pending_i(cfg_pending_i),
        .cfg_curr_addr_i(cfg_curr_addr_i), .cfg_bytes_left_i(cfg_bytes_left_i),
        .udma_cmd_i(udma_cmd_i), .udma_cmd_valid_i(udma_cmd_valid_i),
        .udma_cmd_ready_i(udma_cmd_ready_i)
    );

    function automatic logic [63:0] actualOf(input int sel, input int ch);
        logic rd_ok;
        rd_ok = cfg_valid_i && cfg_rwn_i && cfg_ready_o;
        case (sel)
            S_RD:      return rd_ok ? 64'(cfg_data_o) : 'x;
            S_RD2:     return rd_ok ? 64'(cfg_data_o2) : 'x;
            S_RDY:     return 64'(cfg_ready_o);
            S_SIZE:    return 64'(cfg_size_o >> (16 * ch)) & 64'hFFFF;
            S_DS:      return 64'(cfg_datasize_o >> (2 * ch)) & 64'h3;
            S_SADDR:   return 64'(cfg_startaddr_o >> (12 * ch)) & 64'hFFF;
            S_EN:      return 64'(cfg_en_o);
            S_CLR:     return 64'(cfg_clr_o);
            S_DSALL:   return 64'(cfg_datasize_o);
            S_SIZEALL: return 64'(cfg_size_o);
            default:   return 64'(cfg_continuous_o);
        endcase
    endfunction

    // Monitor: drain every queued expectation at the falling edge, where the
    // DUT outputs (and any read handshake in flight) are stable.
    always @(negedge clk_i) begin
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            act = actualOf(cur.sel, cur.ch);
            n_compared++;
            if (act !== cur.exp) begin
                n_mismatched++;
                $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input int sel, input int ch, input logic [63:0] exp);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.ch   = ch;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic readCheck(input string name, input logic [4:0] addr, input logic [31:0] exp);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = addr;
        checkOutput(name, S_RD, 0, 64'(exp));
        settle();
        cfg_valid_i = 1'b0;
    endtask

    task automatic readBoth(input string name, input logic [4:0] addr,
                            input logic [31:0] exp, input logic [31:0] exp2);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = addr;
        checkOutput(name, S_RD, 0, 64'(exp));
        checkOutput({name, "_cntw2"}, S_RD2, 0, 64'(exp2));
        settle();
        cfg_valid_i = 1'b0;
    endtask

    task automatic cfgWrite(input logic [4:0] addr, input logic [31:0] data);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = addr;
        cfg_data_i  = data;
        tick();
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
    endtask

    task automatic applyStimulus(input logic [31:0] cmd);
        udma_cmd_i       = cmd;
        udma_cmd_valid_i = 1'b1;
        tick();
        udma_cmd_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] mkCmd(input logic [3:0] op, input logic [2:0] ch,
                                          input logic [1:0] ds, input logic [22:0] low);
        return {op, ch, ds, low};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfg_curr_addr_i[2]  = 12'h123;
        cfg_bytes_left_i[1] = 16'hBEEF;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        checkOutput("rst_datasize", S_DSALL, 0, 64'h2A);
        checkOutput("rst_ready", S_RDY, 0, 64'h1);
        checkOutput("rst_en", S_EN, 0, 64'h0);
        checkOutput("rst_size", S_SIZEALL, 0, 64'h0);
        settle();

        // en at bit4, reset datasize 2'b10 at [2:1]
        cfg_en_i = 3'b010;
        tick();
        readCheck("ch1_cfg_read", 5'd6, 32'h14);
        cfg_en_i = 3'b000;
        tick();
        readCheck("ch2_saddr_read", 5'd8, 32'h123);
        readCheck("ch1_size_read", 5'd5, 32'hBEEF);
        readCheck("unmapped_read", 5'd12, 32'h0);

        applyStimulus(mkCmd(4'hE, 3'd2, 2'd1, 23'h40));
        checkOutput("ucs_idle_size2", S_SIZE, 2, 64'h40);
        checkOutput("ucs_idle_ds", S_DSALL, 0, 64'h1A);
        checkOutput("ucs_idle_en", S_EN, 0, 64'h4);
        checkOutput("ucs_idle_size1", S_SIZE, 1, 64'h0);
        settle();
        tick();
        checkOutput("ucs_idle_en_end", S_EN, 0, 64'h0);
        settle();

        cfg_pending_i = 3'b010;
        applyStimulus(mkCmd(4'hE, 3'd1, 2'd3, 23'h20));
        checkOutput("defer_no_en", S_EN, 0, 64'h0);
        checkOutput("defer_size1", S_SIZE, 1, 64'h0);
        settle();
        readCheck("defer_status", 5'd7, 32'h101);
        applyStimulus(mkCmd(4'hE, 3'd1, 2'd0, 23'h30));
        readCheck("ovf_status", 5'd7, 32'h103);
        cfg_pending_i = 3'b000;
        tick();
        checkOutput("apply_size1", S_SIZE, 1, 64'h20);
        checkOutput("apply_ds1", S_DS, 1, 64'h3);
        checkOutput("apply_en", S_EN, 0, 64'h2);
        settle();
        readCheck("apply_status", 5'd7, 32'h102);
        tick();
        checkOutput("apply_en_end", S_EN, 0, 64'h0);
        settle();
        cfgWrite(5'd7, 32'h2);
        readCheck("ovf_w1c", 5'd7, 32'h100);

        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = 5'd9;
        cfg_data_i  = 32'h10;
        udma_cmd_i  = mkCmd(4'hD, 3'd2, 2'd0, 23'hABC);
        udma_cmd_valid_i = 1'b1;
        checkOutput("collide_ready_low", S_RDY, 0, 64'h0);
        settle();
        tick();
        udma_cmd_valid_i = 1'b0;
        checkOutput("collide_saddr2", S_SADDR, 2, 64'hABC);
        checkOutput("collide_ready_high", S_RDY, 0, 64'h1);
        checkOutput("collide_size_held", S_SIZE, 2, 64'h40);
        settle();
        tick();
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
        checkOutput("collide_size2", S_SIZE, 2, 64'h10);
        settle();

        cfgWrite(5'd10, 32'h31);
        checkOutput("cfg_clr", S_CLR, 0, 64'h4);
        checkOutput("cfg_en", S_EN, 0, 64'h4);
        checkOutput("cfg_ds2", S_DS, 2, 64'h0);
        checkOutput("cfg_cont", S_CONT, 0, 64'h4);
        settle();
        cfgWrite(5'd2, 32'h3);
        checkOutput("ch0_ds_fixed", S_DS, 0, 64'h2);
        checkOutput("ch0_cont", S_CONT, 0, 64'h5);
        checkOutput("clr_end", S_CLR, 0, 64'h0);
        settle();

        cfg_pending_i = 3'b100;
        applyStimulus(mkCmd(4'hE, 3'd2, 2'd1, 23'h55));
        cfg_pending_i = 3'b000;
        cfgWrite(5'd10, 32'h20);
        checkOutput("clr_vs_apply_clr", S_CLR, 0, 64'h4);
        checkOutput("clr_vs_apply_en", S_EN, 0, 64'h0);
        checkOutput("clr_vs_apply_size", S_SIZE, 2, 64'h10);
        settle();
        readCheck("clr_vs_apply_status", 5'd11, 32'h0);

        cfgWrite(5'd7, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cfg_en_i[1] = 1'b1;
            tick();
            cfg_en_i[1] = 1'b0;
            tick();
        end
        readBoth("cnt_three", 5'd7, 32'h300, 32'h300);
        cfg_en_i[1] = 1'b1;
        tick();
        cfg_en_i[1] = 1'b0;
        tick();
        readBoth("cnt_four", 5'd7, 32'h400, 32'h300);
        cfg_en_i[1] = 1'b1;
        tick();
        cfg_en_i[1] = 1'b0;
        cfgWrite(5'd7, 32'h4);
        readBoth("cnt_clear_wins", 5'd7, 32'h0, 32'h0);

        applyStimulus(mkCmd(4'hE, 3'd0, 2'd0, 23'h77));
        checkOutput("ucs_ch0_size", S_SIZEALL, 0, 64'h0010_0020_0000);
        checkOutput("ucs_ch0_en", S_EN, 0, 64'h0);
        settle();
        applyStimulus(mkCmd(4'hE, 3'd5, 2'd0, 23'h77));
        checkOutput("ucs_ch5_size", S_SIZEALL, 0, 64'h0010_0020_0000);
        checkOutput("ucs_ch5_ds", S_DSALL, 0, 64'h0E);
        checkOutput("ucs_ch5_en", S_EN, 0, 64'h0);
        settle();
        tick();

        if (sbq.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
